// File: rtl/wide_reg_sequencer_pkg.sv
// Shared sizes, state encodings and the word-count check for the wide-register load sequencer.
package wide_reg_sequencer_pkg;

  localparam int unsigned WORDS  = 16;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned OFS_W  = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // A load must cover 1..WORDS words; anything else is refused with an err pulse.
  function automatic logic count_ok(input logic [OFS_W:0] count);
    return (count != '0) && (count <= (OFS_W + 1)'(WORDS));
  endfunction

endpackage

// File: rtl/wide_reg_sequencer.sv
// Fills a window of the 512-bit wide write-data register from a host word stream,
// sharing the single wide-write port with execute-stage writes, which always win.
module wide_reg_sequencer
  import wide_reg_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [OFS_W-1:0]  i_start_offset,
  input  logic [OFS_W:0]    i_word_count,
  input  logic              i_abort,
  input  logic              i_s_valid,
  input  logic [WORD_W-1:0] i_s_data,
  output logic              o_s_ready,
  input  logic              i_ex_wide_wen,
  input  logic [OFS_W-1:0]  i_ex_wide_offset,
  input  logic [WORD_W-1:0] i_ex_wdata,
  output logic              o_rf_wide_wen,
  output logic [OFS_W-1:0]  o_rf_wide_offset,
  output logic [WORD_W-1:0] o_rf_wdata0,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [OFS_W-1:0]  r_cur_ofs;
  logic [OFS_W:0]    r_remaining;
  logic              r_rf_wen;
  logic [OFS_W-1:0]  r_rf_ofs;
  logic [WORD_W-1:0] r_rf_data;
  logic              r_err;

  logic w_in_idle;
  logic w_in_load;
  logic w_s_ready;
  logic w_beat;
  logic w_last_beat;
  logic w_count_ok;
  logic w_start_ok;

  assign w_in_idle   = (r_state == ST_IDLE);
  assign w_in_load   = (r_state == ST_LOAD);
  assign w_count_ok  = count_ok(i_word_count);
  assign w_start_ok  = w_in_idle && i_start && w_count_ok;
  // Host stalls whenever execute owns the write port or the load is being cancelled.
  assign w_s_ready   = w_in_load && !i_ex_wide_wen && !i_abort;
  assign w_beat      = w_s_ready && i_s_valid;
  assign w_last_beat = w_beat && (r_remaining == (OFS_W + 1)'(1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start_ok) w_state_nxt = ST_LOAD;
      ST_LOAD: if (i_abort || w_last_beat) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cur_ofs   <= '0;
      r_remaining <= '0;
      r_rf_wen    <= 1'b0;
      r_rf_ofs    <= '0;
      r_rf_data   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_in_idle && i_start && !w_count_ok;

      if (w_start_ok) begin
        r_cur_ofs   <= i_start_offset;
        r_remaining <= i_word_count;
      end else if (w_beat) begin
        r_cur_ofs   <= r_cur_ofs + OFS_W'(1);
        r_remaining <= r_remaining - (OFS_W + 1)'(1);
      end

      // Offset/data hold their last value while no write is granted.
      r_rf_wen <= i_ex_wide_wen || w_beat;
      if (i_ex_wide_wen) begin
        r_rf_ofs  <= i_ex_wide_offset;
        r_rf_data <= i_ex_wdata;
      end else if (w_beat) begin
        r_rf_ofs  <= r_cur_ofs;
        r_rf_data <= i_s_data;
      end
    end
  end

  assign o_s_ready        = w_s_ready;
  assign o_rf_wide_wen    = r_rf_wen;
  assign o_rf_wide_offset = r_rf_ofs;
  assign o_rf_wdata0      = r_rf_data;
  assign o_busy           = w_in_load;
  assign o_done           = (r_state == ST_DONE);
  assign o_err            = r_err;

endmodule

// File: tb/tb_wide_reg_sequencer.sv
// Scoreboard bench: directed loads push hand-computed register-file writes; a monitor pops them.
module tb_wide_reg_sequencer;
  import wide_reg_sequencer_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_start;
  logic [OFS_W-1:0]  i_start_offset;
  logic [OFS_W:0]    i_word_count;
  logic              i_abort;
  logic              i_s_valid;
  logic [WORD_W-1:0] i_s_data;
  logic              o_s_ready;
  logic              i_ex_wide_wen;
  logic [OFS_W-1:0]  i_ex_wide_offset;
  logic [WORD_W-1:0] i_ex_wdata;
  logic              o_rf_wide_wen;
  logic [OFS_W-1:0]  o_rf_wide_offset;
  logic [WORD_W-1:0] o_rf_wdata0;
  logic              o_busy;
  logic              o_done;
  logic              o_err;

  always #5 clk = ~clk;

  wide_reg_sequencer u_dut (
    .clk              (clk),
    .rst              (rst),
    .i_start          (i_start),
    .i_start_offset   (i_start_offset),
    .i_word_count     (i_word_count),
    .i_abort          (i_abort),
    .i_s_valid        (i_s_valid),
    .i_s_data         (i_s_data),
    .o_s_ready        (o_s_ready),
    .i_ex_wide_wen    (i_ex_wide_wen),
    .i_ex_wide_offset (i_ex_wide_offset),
    .i_ex_wdata       (i_ex_wdata),
    .o_rf_wide_wen    (o_rf_wide_wen),
    .o_rf_wide_offset (o_rf_wide_offset),
    .o_rf_wdata0      (o_rf_wdata0),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_err            (o_err)
  );

  typedef struct packed {
    logic [OFS_W-1:0]  ofs;
    logic [WORD_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_vec = 0;
  int  n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [OFS_W-1:0] ofs, input logic [WORD_W-1:0] data);
    wr_t e;
    e.ofs  = ofs;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every granted write must match the next expected one, in order.
  always @(negedge clk) begin
    if (o_rf_wide_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got ofs %0d data 0x%0h, expected no write",
                 o_rf_wide_offset, o_rf_wdata0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_ofs", 32'(o_rf_wide_offset), 32'(mon_e.ofs));
        chk("wr_data", o_rf_wdata0, mon_e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [OFS_W-1:0] ofs, input logic [OFS_W:0] cnt);
    i_start_offset = ofs;
    i_word_count   = cnt;
    i_start        = 1'b1;
    tick();
    i_start        = 1'b0;
  endtask

  // Streams host words base+k; execute writes occupy ex_len cycles once ex_at beats are in,
  // abort is raised once abort_at beats are in. Checks s_ready every cycle.
  task automatic run_host(input int n, input logic [31:0] base, input int ex_at,
                          input int ex_len, input logic [OFS_W-1:0] ex_ofs,
                          input logic [31:0] ex_dat, input int abort_at);
    int   acc = 0;
    int   exn = 0;
    int   cyc = 0;
    logic ex;
    logic ab;
    while (acc < n) begin
      if (cyc >= 64) begin
        n_vec++;
        n_err++;
        $display("FAIL host_timeout: got %0d beats, expected %0d", acc, n);
        break;
      end
      ex = (acc == ex_at) && (exn < ex_len);
      ab = (acc == abort_at) && !ex;
      i_ex_wide_wen    = ex;
      i_ex_wide_offset = ex_ofs;
      i_ex_wdata       = ex_dat;
      i_abort          = ab;
      i_s_valid        = 1'b1;
      i_s_data         = base + 32'(acc);
      #1;
      chk("s_ready", 32'(o_s_ready), 32'(!ex && !ab));
      tick();
      cyc++;
      if (ex) exn++;
      else if (ab) break;
      else acc++;
    end
    i_s_valid     = 1'b0;
    i_ex_wide_wen = 1'b0;
    i_abort       = 1'b0;
  endtask

  task automatic drain();
    tick();
    tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    rst              = 1'b1;
    i_start          = 1'b0;
    i_start_offset   = '0;
    i_word_count     = '0;
    i_abort          = 1'b0;
    i_s_valid        = 1'b0;
    i_s_data         = '0;
    i_ex_wide_wen    = 1'b0;
    i_ex_wide_offset = '0;
    i_ex_wdata       = '0;
    tick();
    tick();
    chk("rst_s_ready", 32'(o_s_ready), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_wen", 32'(o_rf_wide_wen), 32'd0);
    chk("rst_ofs", 32'(o_rf_wide_offset), 32'd0);
    chk("rst_data", o_rf_wdata0, 32'd0);
    rst = 1'b0;
    tick();

    // Full 16-word load from offset 0.
    for (int i = 0; i < 16; i++) push(4'(i), 32'h1000 + 32'(i));
    do_start(4'd0, 5'd16);
    chk("full_busy", 32'(o_busy), 32'd1);
    run_host(16, 32'h1000, -1, 0, 4'd0, 32'd0, -1);
    chk("full_done", 32'(o_done), 32'd1);
    chk("full_busy_done", 32'(o_busy), 32'd0);
    tick();
    chk("full_done_clr", 32'(o_done), 32'd0);
    chk("hold_ofs", 32'(o_rf_wide_offset), 32'd15);
    chk("hold_data", o_rf_wdata0, 32'h100F);
    drain();

    // Wrap around the top of the register; start during DONE is ignored.
    push(4'd14, 32'h3000);
    push(4'd15, 32'h3001);
    push(4'd0, 32'h3002);
    push(4'd1, 32'h3003);
    do_start(4'd14, 5'd4);
    run_host(4, 32'h3000, -1, 0, 4'd0, 32'd0, -1);
    chk("wrap_done", 32'(o_done), 32'd1);
    i_word_count = 5'd0;
    i_start      = 1'b1;
    tick();
    i_start = 1'b0;
    chk("done_start_err", 32'(o_err), 32'd0);
    chk("done_start_busy", 32'(o_busy), 32'd0);
    chk("wrap_done_once", 32'(o_done), 32'd0);
    drain();

    // Execute contention: three execute writes after two host beats.
    push(4'd0, 32'h2000);
    push(4'd1, 32'h2001);
    push(4'd5, 32'hDEAD);
    push(4'd5, 32'hDEAD);
    push(4'd5, 32'hDEAD);
    push(4'd2, 32'h2002);
    push(4'd3, 32'h2003);
    push(4'd4, 32'h2004);
    push(4'd5, 32'h2005);
    do_start(4'd0, 5'd6);
    i_s_valid = 1'b0;
    #1;
    chk("ready_no_valid", 32'(o_s_ready), 32'd1);
    tick();
    run_host(6, 32'h2000, 2, 3, 4'd5, 32'hDEAD, -1);
    chk("cont_done", 32'(o_done), 32'd1);
    drain();

    // Rejected word counts.
    do_start(4'd3, 5'd0);
    chk("bad0_err", 32'(o_err), 32'd1);
    chk("bad0_busy", 32'(o_busy), 32'd0);
    tick();
    chk("bad0_err_clr", 32'(o_err), 32'd0);
    do_start(4'd3, 5'd17);
    chk("bad17_err", 32'(o_err), 32'd1);
    chk("bad17_busy", 32'(o_busy), 32'd0);
    drain();

    // Abort after three beats, then a one-word load.
    push(4'd2, 32'h4000);
    push(4'd3, 32'h4001);
    push(4'd4, 32'h4002);
    do_start(4'd2, 5'd8);
    run_host(8, 32'h4000, -1, 0, 4'd0, 32'd0, 3);
    chk("abort_done", 32'(o_done), 32'd1);
    chk("abort_busy", 32'(o_busy), 32'd0);
    tick();
    chk("abort_idle_ready", 32'(o_s_ready), 32'd0);
    push(4'd9, 32'h4100);
    do_start(4'd9, 5'd1);
    chk("after_abort_busy", 32'(o_busy), 32'd1);
    run_host(1, 32'h4100, -1, 0, 4'd0, 32'd0, -1);
    chk("after_abort_done", 32'(o_done), 32'd1);
    drain();

    // Reset in the middle of a load.
    for (int i = 0; i < 5; i++) push(4'(i), 32'h5000 + 32'(i));
    do_start(4'd0, 5'd8);
    run_host(5, 32'h5000, -1, 0, 4'd0, 32'd0, -1);
    i_s_valid = 1'b1;
    rst       = 1'b1;
    tick();
    chk("mrst_s_ready", 32'(o_s_ready), 32'd0);
    chk("mrst_busy", 32'(o_busy), 32'd0);
    chk("mrst_done", 32'(o_done), 32'd0);
    chk("mrst_wen", 32'(o_rf_wide_wen), 32'd0);
    chk("mrst_ofs", 32'(o_rf_wide_offset), 32'd0);
    chk("mrst_data", o_rf_wdata0, 32'd0);
    rst       = 1'b0;
    i_s_valid = 1'b0;
    tick();
    chk("mrst_no_done", 32'(o_done), 32'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
